// File: rtl/seq_mul.sv
// Iterative radix-2 Booth multiplier: one Booth step per clock, full 2*WIDTH-bit product,
// runtime signed/unsigned mode, start/ready/busy/out_valid handshake.
module seq_mul #(
    parameter int WIDTH = 6,
    parameter int CNT_W = $clog2(WIDTH+2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sel,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   out
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state, w_state_nxt;
    logic [WIDTH+1:0]     r_acc;
    logic [WIDTH:0]       r_q;
    logic                 r_q_m1;
    logic [WIDTH+1:0]     r_m;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   r_out;

    logic                 w_load;
    logic                 w_last;
    logic                 w_a_sgn;
    logic                 w_b_sgn;
    logic [WIDTH+1:0]     w_sum;
    logic [WIDTH+1:0]     w_acc_nxt;
    logic [WIDTH:0]       w_q_nxt;

    assign ready   = (r_state == S_IDLE) || (r_state == S_DONE);
    assign busy    = (r_state == S_RUN);
    assign w_load  = ready && start;
    assign w_last  = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH));
    // Zero-extension turns unsigned operands into non-negative signed ones,
    // so the same signed Booth recurrence covers both modes.
    assign w_a_sgn = sel && a[WIDTH-1];
    assign w_b_sgn = sel && b[WIDTH-1];

    always_comb begin
        w_sum = r_acc;
        case ({r_q[0], r_q_m1})
            2'b01:   w_sum = r_acc + r_m;
            2'b10:   w_sum = r_acc - r_m;
            default: w_sum = r_acc;
        endcase
    end

    assign w_acc_nxt = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
    assign w_q_nxt   = {w_sum[0], r_q[WIDTH:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_q         <= '0;
            r_q_m1      <= 1'b0;
            r_m         <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else begin
            r_out_valid <= w_last;
            if (w_load) begin
                r_acc  <= '0;
                r_q    <= {w_b_sgn, b};
                r_q_m1 <= 1'b0;
                r_m    <= {{2{w_a_sgn}}, a};
                r_cnt  <= '0;
            end else if (r_state == S_RUN) begin
                r_acc  <= w_acc_nxt;
                r_q    <= w_q_nxt;
                r_q_m1 <= r_q[0];
                r_cnt  <= r_cnt + CNT_W'(1);
            end
            // Product is the low 2*WIDTH bits of {A,Q} after the final shift.
            if (w_last) r_out <= {w_acc_nxt[WIDTH-2:0], w_q_nxt};
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;

endmodule
